// File: rtl/darkram_arb_pkg.sv
// darkram_arb_pkg: shared definitions for the single-port RAM arbiter.
// FSM state encoding, owner encoding and the "is this X request grantable"
// helper used by both the top and its grant selector.
package darkram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_ACK  = 2'd3
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_X = 1'b1;

    // An X request only competes when it names an operation; a bare XDREQ
    // with neither XRD nor XWR is never granted.
    function automatic logic x_req_valid(input logic dreq, input logic rd, input logic wr);
        return dreq & (rd | wr);
    endfunction

endpackage

// File: rtl/darkram_arb_pick.sv
// darkram_arb_pick: combinational grant selector for darkram_arb.
// Build option: DARKRAM_ARB_RR_EN selects round-robin between I and X on
// simultaneous requests (the one that was not the last owner wins). When
// the macro is undefined X always beats I and last_owner is not a port.
module darkram_arb_pick
    import darkram_arb_pkg::*;
(
`ifdef DARKRAM_ARB_RR_EN
    input  logic last_owner,
`endif
    input  logic ireq,
    input  logic xreq,
    input  logic HLT,
    output logic grant_valid,
    output logic grant_x
);

    // Halt only gates new grants; it never touches the winner choice.
    assign grant_valid = ~HLT & (ireq | xreq);

`ifdef DARKRAM_ARB_RR_EN
    // On a tie, hand the RAM to whoever did not have it last time.
    assign grant_x = xreq & (~ireq | (last_owner == OWN_I));
`else
    // Fixed priority: the data port always wins a tie.
    assign grant_x = xreq;
`endif

endmodule

// File: rtl/darkram_arb.sv
// darkram_arb: shares one single-port synchronous RAM between the core's
// instruction-fetch port (I) and data port (X). Accesses are serialised
// through IDLE -> CMD -> (WAIT) -> ACK; all RAM-side command outputs and
// core-side read data / acknowledges are registered.
// Build option: DARKRAM_ARB_RR_EN enables round-robin arbitration (with a
// last-owner register); otherwise X has fixed priority over I.
module darkram_arb
    import darkram_arb_pkg::*;
#(
    parameter int AW     = 11,  // RAM word-address width
    parameter int RD_LAT = 1    // RAM read latency, 1..3 cycles
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          HLT,
    input  logic          IDREQ,
    input  logic [31:0]   IADDR,
    output logic [31:0]   IDATA,
    output logic          IDACK,
    input  logic          XDREQ,
    input  logic          XRD,
    input  logic          XWR,
    input  logic [3:0]    XBE,
    input  logic [31:0]   XADDR,
    input  logic [31:0]   XATAI,
    output logic [31:0]   XATAO,
    output logic          XDACK,
    output logic [AW-1:0] RADDR,
    output logic          RWE,
    output logic [3:0]    RBE,
    output logic [31:0]   RDATI,
    input  logic [31:0]   RDATO,
    output logic [3:0]    DEBUG
);

    state_e        state_q;
    logic          owner_q;     // OWN_I / OWN_X of the access in flight
    logic          wr_q;        // access in flight is a write
    logic [1:0]    cnt_q;       // remaining WAIT cycles before RDATO is valid
    logic [AW-1:0] raddr_q;
    logic          rwe_q;
    logic [3:0]    rbe_q;
    logic [31:0]   rdati_q;
    logic [31:0]   idata_q;
    logic [31:0]   xatao_q;
    logic          idack_q;
    logic          xdack_q;
`ifdef DARKRAM_ARB_RR_EN
    logic          last_owner_q;
`endif

    logic          xreq_valid;
    logic          grant_valid;
    logic          grant_x;
    logic          wr_d;
    logic [AW-1:0] raddr_d;

    // Byte address bits above the RAM size wrap; the byte offset is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IADDR[31:AW+2], IADDR[1:0], XADDR[31:AW+2], XADDR[1:0]};

    assign xreq_valid = x_req_valid(XDREQ, XRD, XWR);

    darkram_arb_pick u_pick (
`ifdef DARKRAM_ARB_RR_EN
        .last_owner  (last_owner_q),
`endif
        .ireq        (IDREQ),
        .xreq        (xreq_valid),
        .HLT         (HLT),
        .grant_valid (grant_valid),
        .grant_x     (grant_x)
    );

    // XRD and XWR together is treated as a write.
    assign wr_d    = grant_x & XWR;
    assign raddr_d = grant_x ? XADDR[AW+1:2] : IADDR[AW+1:2];

    // Access sequencer: grant in IDLE, one command cycle, optional read wait, one ack cycle.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            wr_q         <= 1'b0;
            cnt_q        <= 2'd0;
            raddr_q      <= '0;
            rwe_q        <= 1'b0;
            rbe_q        <= 4'b0;
            rdati_q      <= 32'b0;
            idata_q      <= 32'b0;
            xatao_q      <= 32'b0;
            idack_q      <= 1'b0;
            xdack_q      <= 1'b0;
`ifdef DARKRAM_ARB_RR_EN
            last_owner_q <= OWN_I;
`endif
        end else begin
            // Acks are single-cycle pulses raised only on entry to ACK.
            idack_q <= 1'b0;
            xdack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        state_q <= S_CMD;
                        owner_q <= grant_x;
                        wr_q    <= wr_d;
                        raddr_q <= raddr_d;
                        rwe_q   <= wr_d;
                        rbe_q   <= wr_d ? XBE : 4'b0;
                        if (wr_d) begin
                            rdati_q <= XATAI;
                        end
`ifdef DARKRAM_ARB_RR_EN
                        last_owner_q <= grant_x;
`endif
                    end
                end
                S_CMD: begin
                    // The RAM has sampled the command; keep the write strobe one cycle wide.
                    rwe_q <= 1'b0;
                    rbe_q <= 4'b0;
                    if (wr_q) begin
                        state_q <= S_ACK;
                        idack_q <= (owner_q == OWN_I);
                        xdack_q <= (owner_q == OWN_X);
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= 2'(RD_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        // Only the owner's read-data register is updated.
                        if (owner_q == OWN_X) begin
                            xatao_q <= RDATO;
                        end else begin
                            idata_q <= RDATO;
                        end
                        state_q <= S_ACK;
                        idack_q <= (owner_q == OWN_I);
                        xdack_q <= (owner_q == OWN_X);
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_ACK: begin
                    // No grant here, so a request still held from this access is not regranted.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign RADDR = raddr_q;
    assign RWE   = rwe_q;
    assign RBE   = rbe_q;
    assign RDATI = rdati_q;
    assign IDATA = idata_q;
    assign XATAO = xatao_q;
    assign IDACK = idack_q;
    assign XDACK = xdack_q;
    assign DEBUG = {state_q, owner_q, rwe_q};

endmodule

// File: tb/tb_darkram_arb.sv
// tb_darkram_arb: randomized and directed bench for darkram_arb.
// Requester processes drive the I and X handshakes from transaction queues;
// a transaction-level reference (arbitration rule, grant spacing, latency,
// word-addressed memory mirror) pushes expected acks into a scoreboard that
// a monitor pops whenever the DUT acknowledges.
module tb_darkram_arb;

    localparam int AW     = 11;
    localparam int RD_LAT = 1;

    logic          CLK = 1'b0;
    logic          RES;
    logic          HLT;
    logic          IDREQ;
    logic [31:0]   IADDR;
    logic [31:0]   IDATA;
    logic          IDACK;
    logic          XDREQ, XRD, XWR;
    logic [3:0]    XBE;
    logic [31:0]   XADDR, XATAI, XATAO;
    logic          XDACK;
    logic [AW-1:0] RADDR;
    logic          RWE;
    logic [3:0]    RBE;
    logic [31:0]   RDATI, RDATO;
    logic [3:0]    DEBUG;

    always #5 CLK = ~CLK;

    darkram_arb #(.AW(AW), .RD_LAT(RD_LAT)) u_dut (
        .CLK(CLK), .RES(RES), .HLT(HLT),
        .IDREQ(IDREQ), .IADDR(IADDR), .IDATA(IDATA), .IDACK(IDACK),
        .XDREQ(XDREQ), .XRD(XRD), .XWR(XWR), .XBE(XBE), .XADDR(XADDR),
        .XATAI(XATAI), .XATAO(XATAO), .XDACK(XDACK),
        .RADDR(RADDR), .RWE(RWE), .RBE(RBE), .RDATI(RDATI), .RDATO(RDATO),
        .DEBUG(DEBUG)
    );

    // Second instance with the slowest RAM, driven by a short directed sequence.
    logic          x3req = 1'b0, x3rd = 1'b0;
    logic [31:0]   x3addr = 32'b0;
    logic          ireq3 = 1'b0, xwr3 = 1'b0, hlt3 = 1'b0;
    logic [31:0]   iaddr3 = 32'b0, xatai3 = 32'b0;
    logic [3:0]    xbe3 = 4'b0;
    logic [31:0]   idata3, xatao3, rdati3, rdato3;
    logic          iack3, xack3, rwe3;
    logic [AW-1:0] raddr3;
    logic [3:0]    rbe3, debug3;

    darkram_arb #(.AW(AW), .RD_LAT(3)) u_dut3 (
        .CLK(CLK), .RES(RES), .HLT(hlt3),
        .IDREQ(ireq3), .IADDR(iaddr3), .IDATA(idata3), .IDACK(iack3),
        .XDREQ(x3req), .XRD(x3rd), .XWR(xwr3), .XBE(xbe3), .XADDR(x3addr),
        .XATAI(xatai3), .XATAO(xatao3), .XDACK(xack3),
        .RADDR(raddr3), .RWE(rwe3), .RBE(rbe3), .RDATI(rdati3), .RDATO(rdato3),
        .DEBUG(debug3)
    );

    function automatic logic [31:0] init_word(input int unsigned w);
        if (w == 4) return 32'hDEADBEEF;
        return (w * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        return (a / 4) % (1 << AW);
    endfunction

    // ---------------- RAM models ----------------
    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    bit          preloaded = 1'b0;
    always @(posedge CLK) begin
        if (!preloaded) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
            preloaded <= 1'b1;
        end else if (RWE) begin
            for (int b = 0; b < 4; b++)
                if (RBE[b]) ram[RADDR][8*b +: 8] <= RDATI[8*b +: 8];
        end
        rd_pipe[0] <= ram[RADDR];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign RDATO = rd_pipe[RD_LAT-1];

    logic [31:0] p3 [0:2];
    always @(posedge CLK) begin
        p3[0] <= init_word(32'(raddr3));
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdato3 = p3[2];

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_idata"}, IDATA, 32'h0);
        chk({tag, "_xatao"}, XATAO, 32'h0);
        chk({tag, "_acks"},  32'({IDACK, XDACK}), 32'h0);
        chk({tag, "_raddr"}, 32'(RADDR), 32'h0);
        chk({tag, "_rwe"},   32'(RWE), 32'h0);
        chk({tag, "_rbe"},   32'(RBE), 32'h0);
        chk({tag, "_rdati"}, RDATI, 32'h0);
        chk({tag, "_debug"}, 32'(DEBUG), 32'h0);
    endtask

    // ---------------- requesters ----------------
    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] dat;
        int          gap;
    } req_t;

    req_t iq[$];
    req_t xq[$];
    bit   i_busy = 1'b0;
    bit   x_busy = 1'b0;

    initial begin
        bit   ack_now;
        int   gcnt;
        req_t t;
        gcnt  = 0;
        IDREQ = 1'b0;
        IADDR = 32'b0;
        forever begin
            @(negedge CLK);
            ack_now = (IDACK === 1'b1) && (RES === 1'b1);
            @(posedge CLK);
            #1;
            if (i_busy && ack_now) begin
                IDREQ  = 1'b0;
                i_busy = 1'b0;
            end
            if (!i_busy && iq.size() != 0) begin
                if (gcnt < iq[0].gap) gcnt++;
                else begin
                    t      = iq.pop_front();
                    IADDR  = t.addr;
                    IDREQ  = 1'b1;
                    i_busy = 1'b1;
                    gcnt   = 0;
                end
            end
        end
    end

    initial begin
        bit   ack_now;
        int   gcnt, hold;
        req_t t;
        gcnt  = 0;
        hold  = 0;
        XDREQ = 1'b0; XRD = 1'b0; XWR = 1'b0;
        XBE   = 4'b0; XADDR = 32'b0; XATAI = 32'b0;
        forever begin
            @(negedge CLK);
            ack_now = (XDACK === 1'b1) && (RES === 1'b1);
            @(posedge CLK);
            #1;
            if (x_busy && !XRD && !XWR) hold++;
            if (x_busy && (ack_now || hold >= 20)) begin
                XDREQ  = 1'b0; XRD = 1'b0; XWR = 1'b0;
                x_busy = 1'b0;
                hold   = 0;
            end
            if (!x_busy && xq.size() != 0) begin
                if (gcnt < xq[0].gap) gcnt++;
                else begin
                    t      = xq.pop_front();
                    XADDR  = t.addr; XRD = t.rd; XWR = t.wr;
                    XBE    = t.be;   XATAI = t.dat;
                    XDREQ  = 1'b1;
                    x_busy = 1'b1;
                    gcnt   = 0;
                end
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    typedef struct {
        bit          is_x;
        bit          is_wr;
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    bit          ack_log[$];
    int          n_iack = 0;
    int          n_xack = 0;
    logic [31:0] mirror [int];

    function automatic logic [31:0] mirror_rd(input int unsigned w);
        if (mirror.exists(int'(w))) return mirror[int'(w)];
        return init_word(w);
    endfunction

    initial begin
        int unsigned free_cyc, cmd_cyc, w;
        bit          last_x, cmd_pend, cmd_we, xv, iv, win_x, is_wr;
        logic [31:0] cmd_addr, cmd_dat, exp_idata, exp_xatao, v;
        logic [3:0]  cmd_be;
        exp_t        e;
        free_cyc = 0; last_x = 1'b0; cmd_pend = 1'b0;
        exp_idata = 32'b0; exp_xatao = 32'b0;
        cmd_cyc = 0; cmd_we = 1'b0; cmd_addr = 32'b0; cmd_dat = 32'b0; cmd_be = 4'b0;
        forever begin
            @(negedge CLK);
            if (RES !== 1'b1) begin
                sbq.delete();
                free_cyc  = 0;
                last_x    = 1'b0;
                cmd_pend  = 1'b0;
                exp_idata = 32'b0;
                exp_xatao = 32'b0;
            end else begin
                // acknowledges
                if (IDACK === 1'b1 || XDACK === 1'b1) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_ack", 32'({IDACK, XDACK}), 32'h0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ack_owner", 32'({IDACK, XDACK}), e.is_x ? 32'd1 : 32'd2);
                        chk("ack_cycle", cyc, e.cyc);
                        if (!e.is_wr) begin
                            if (e.is_x) exp_xatao = e.data;
                            else        exp_idata = e.data;
                        end
                        chk("idata", IDATA, exp_idata);
                        chk("xatao", XATAO, exp_xatao);
                        ack_log.push_back(e.is_x);
                        if (e.is_x) n_xack++; else n_iack++;
                        $display("[%0d] ack %s %s data=%h", cyc, e.is_x ? "X" : "I",
                                 e.is_wr ? "wr" : "rd", e.is_x ? XATAO : IDATA);
                    end
                end
                if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
                    chk("ack_timeout", cyc, sbq[0].cyc);
                    void'(sbq.pop_front());
                end
                // command cycle: address, write strobe and write payload
                if (cmd_pend && cyc == cmd_cyc) begin
                    chk("cmd_raddr", 32'(RADDR), cmd_addr);
                    chk("cmd_rwe", 32'(RWE), 32'(cmd_we));
                    if (cmd_we) begin
                        chk("cmd_rbe", 32'(RBE), 32'(cmd_be));
                        chk("cmd_rdati", RDATI, cmd_dat);
                    end
                    cmd_pend = 1'b0;
                end else begin
                    chk("rwe_outside_cmd", 32'(RWE), 32'h0);
                end
                // grant decision
                if (cyc >= free_cyc && HLT === 1'b0) begin
                    xv = (XDREQ === 1'b1) && (XRD === 1'b1 || XWR === 1'b1);
                    iv = (IDREQ === 1'b1);
                    if (xv || iv) begin
`ifdef DARKRAM_ARB_RR_EN
                        win_x = xv && (!iv || !last_x);
`else
                        win_x = xv;
`endif
                        last_x = win_x;
                        w      = win_x ? word_of(XADDR) : word_of(IADDR);
                        is_wr  = win_x && XWR;
                        cmd_pend = 1'b1;
                        cmd_cyc  = cyc + 1;
                        cmd_addr = w;
                        cmd_we   = is_wr;
                        cmd_be   = XBE;
                        cmd_dat  = XATAI;
                        e.is_x   = win_x;
                        e.is_wr  = is_wr;
                        e.cyc    = cyc + (is_wr ? 2 : 2 + RD_LAT);
                        e.data   = mirror_rd(w);
                        if (is_wr) begin
                            v = mirror_rd(w);
                            for (int b = 0; b < 4; b++)
                                if (XBE[b]) v[8*b +: 8] = XATAI[8*b +: 8];
                            mirror[int'(w)] = v;
                        end
                        free_cyc = e.cyc + 1;
                        sbq.push_back(e);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((iq.size() != 0 || xq.size() != 0 || i_busy || x_busy || sbq.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
        repeat (2) @(negedge CLK);
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic rd, input logic wr,
                                input logic [3:0] be, input logic [31:0] d, input int gap);
        req_t r;
        r.addr = a; r.rd = rd; r.wr = wr; r.be = be; r.dat = d; r.gap = gap;
        return r;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 31)) << 2) | ($urandom & 32'h3);
    endfunction

    initial begin
        logic [31:0]   tmp;
        logic [AW-1:0] raddr0;
        int            nack0, nack1, n, op;
        int unsigned   w;
        bit            seen;

        RES = 1'b0;
        HLT = 1'b0;
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        @(posedge CLK);
        #1 RES = 1'b1;

        // Preloaded word 4 via the I port.
        @(negedge CLK);
        iq.push_back(mk(32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 0));
        wait_idle(50);
        chk("tp_idata_word4", IDATA, 32'hDEADBEEF);

        // Half-word write on X, then read back through I.
        xq.push_back(mk(32'h20, 1'b0, 1'b1, 4'b0011, 32'h1234ABCD, 0));
        wait_idle(50);
        iq.push_back(mk(32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 0));
        wait_idle(50);
        tmp = init_word(8);
        chk("tp_readback_word8", IDATA, {tmp[31:16], 16'hABCD});

        // Halt blocks the grant; release lets it through.
        @(posedge CLK);
        #1 HLT = 1'b1;
        @(negedge CLK);
        raddr0 = RADDR;
        nack0  = n_iack;
        iq.push_back(mk(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, 0));
        repeat (10) @(negedge CLK);
        chk("hlt_raddr_held", 32'(RADDR), 32'(raddr0));
        chk("hlt_no_ack", 32'(n_iack), 32'(nack0));
        @(posedge CLK);
        #1 HLT = 1'b0;
        wait_idle(50);

        // Halt raised during the command cycle does not stop that access.
        xq.push_back(mk(32'h30, 1'b0, 1'b1, 4'b1111, 32'hCAFEF00D, 0));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge CLK);
            seen = (RWE === 1'b1);
            n++;
        end
        chk("hlt_cmd_seen_rwe", 32'(seen), 32'h1);
        HLT = 1'b1;
        repeat (4) @(posedge CLK);
        #1 HLT = 1'b0;
        wait_idle(50);

        // XDREQ without an operation is never granted.
        nack0 = n_xack;
        nack1 = n_iack;
        xq.push_back(mk(32'h40, 1'b0, 1'b0, 4'hF, 32'h0, 0));
        wait_idle(60);
        chk("noop_no_xack", 32'(n_xack), 32'(nack0));
        chk("noop_no_iack", 32'(n_iack), 32'(nack1));

        // Continuous contention between I and X.
        ack_log.delete();
        for (int k = 0; k < 6; k++) begin
            xq.push_back(mk(rnd_addr(), 1'b1, k[0], 4'($urandom), $urandom, 0));
            iq.push_back(mk(rnd_addr(), 1'b1, 1'b0, 4'h0, 32'h0, 0));
        end
        wait_idle(300);
        chk("contend_count", 32'(ack_log.size()), 32'd12);
        if (ack_log.size() == 12) begin
`ifdef DARKRAM_ARB_RR_EN
            for (int k = 1; k < 12; k++)
                chk("rr_alternates", 32'(ack_log[k]), 32'(!ack_log[k-1]));
`else
            for (int k = 0; k < 12; k++)
                chk("fixed_prio_order", 32'(ack_log[k]), (k < 6) ? 32'd1 : 32'd0);
`endif
        end

        // Asynchronous reset in the middle of a read wait.
        iq.push_back(mk(32'h14, 1'b1, 1'b0, 4'h0, 32'h0, 0));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge CLK);
            seen = (DEBUG[3:2] === 2'd2);
            n++;
        end
        chk("rst_reached_wait", 32'(seen), 32'h1);
        #2 RES = 1'b0;
        #1 chk_zero("async_rst");
        repeat (2) @(posedge CLK);
        #1 RES = 1'b1;
        @(negedge CLK);
        chk("post_rst_idle", 32'(DEBUG[3:2]), 32'h0);
        wait_idle(50);
        chk("post_rst_regrant_data", IDATA, init_word(5));

        // Randomized mix with random halt.
        for (int k = 0; k < 50; k++) begin
            op = $urandom_range(0, 2);
            xq.push_back(mk(rnd_addr(), (op != 1), (op != 0), 4'($urandom), $urandom,
                            $urandom_range(0, 3)));
            iq.push_back(mk(rnd_addr(), 1'b1, 1'b0, 4'h0, 32'h0, $urandom_range(0, 3)));
        end
        fork
            begin
                repeat (300) begin
                    @(posedge CLK);
                    #1 HLT = ($urandom_range(0, 9) == 0);
                end
                HLT = 1'b0;
            end
            wait_idle(4000);
        join
        wait_idle(100);

        // Slow RAM instance: X read acked in cycle 5.
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(0, (1 << AW) - 1);
            @(posedge CLK);
            #1;
            x3addr = ($urandom & 32'hFFFF_E000) | (w << 2);
            x3req  = 1'b1;
            x3rd   = 1'b1;
            n = 0;
            @(negedge CLK);
            while (xack3 !== 1'b1 && n < 20) begin
                @(negedge CLK);
                n++;
            end
            chk("lat3_ack_cycle", 32'(n), 32'd5);
            chk("lat3_xatao", xatao3, init_word(w));
            chk("lat3_idata_held", idata3, 32'h0);
            $display("[%0d] ack X3 rd word=%0d data=%h", cyc, w, xatao3);
            @(posedge CLK);
            #1;
            x3req = 1'b0;
            x3rd  = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/darkram_arb.md
Name: darkram_arb

Overview:
Arbiter/sequencer that shares one single-port synchronous RAM between the core's instruction-fetch port (I) and data port (X). Used on boards whose memory macro offers only one port. It presents the same IDREQ/IDACK and XDREQ/XDACK handshake pair the core already speaks. Sits between the core and the RAM macro and serialises accesses with registered RAM-side command outputs.

Parameters:
AW, 11, RAM word-address width (2048 x 32-bit words)
RD_LAT, 1, RAM read latency in cycles from address-sampling edge to valid RDATO (1..3)

Ports:
CLK  in  1  clock
RES  in  1  reset, asynchronous, active-low
HLT  in  1  halt; blocks new grants, in-flight access completes
IDREQ  in  1  instruction read request, held until IDACK
IADDR  in  32  instruction byte address
IDATA  out  32  instruction read data, registered
IDACK  out  1  one-cycle instruction acknowledge
XDREQ  in  1  data request, held until XDACK
XRD  in  1  data read
XWR  in  1  data write
XBE  in  4  byte enables
XADDR  in  32  data byte address
XATAI  in  32  write data
XATAO  out  32  read data, registered
XDACK  out  1  one-cycle data acknowledge
RADDR  out  AW  RAM word address
RWE  out  1  RAM write enable
RBE  out  4  RAM byte enables
RDATI  out  32  RAM write data
RDATO  in  32  RAM read data
DEBUG  out  4  {state[1:0], owner_is_x, RWE}

Behaviour:
- One clock CLK; reset RES asynchronous, active-low.
- Reset (RES=0, immediate): state IDLE, all outputs 0 (IDATA, XATAO, IDACK, XDACK, RWE, RBE, RADDR, RDATI, DEBUG), last-owner = I. Reset mid-access aborts it; RWE drops without waiting for a clock.
- States: IDLE, CMD, WAIT, ACK.
- IDLE: if HLT=0 and a valid request exists, grant it. Register RADDR = ADDR[AW+1:2] and the owner. Upper address bits are ignored (wrap). For X writes, also register RWE=1, RBE=XBE, RDATI=XATAI. Then go to CMD.
- Valid X request: XDREQ & (XRD|XWR). XRD&XWR together is treated as a write. XDREQ with neither XRD nor XWR is never granted.
- CMD (one cycle): RAM samples the command at the end of this cycle.
  - Write: next state ACK.
  - Read: next state WAIT with counter = RD_LAT-1.
  - RWE returns to 0 on leaving CMD, so it is exactly one cycle wide.
- WAIT: counter decrements each cycle. When the counter is 0, capture RDATO into IDATA or XATAO per owner, then go to ACK.
- ACK (one cycle): IDACK or XDACK=1 for the owner only, then return to IDLE.
  - No grant is sampled in ACK, so a requester's stale held request is never regranted.
  - The non-owner's read-data register holds its previous value.
- Latency, counted from request in IDLE during cycle 0:
  - write ack in cycle 2;
  - read ack in cycle 2+RD_LAT (cycle 3 at default).
  - Minimum spacing between grants: write 3 cycles, read 3+RD_LAT cycles.
- Simultaneous I and X requests: X wins (fixed priority) unless the optional feature is enabled.
- HLT=1 in IDLE: no grant. HLT during CMD/WAIT/ACK has no effect.
- Request dropped before ack: protocol violation; the access still completes and is acked.

Optional Feature:
DARKRAM_ARB_RR_EN
- Defined: round-robin arbitration on simultaneous requests. The requester that was not the last owner wins. Last-owner updates on every grant.
- Undefined: fixed X-over-I priority; the last-owner register is removed.

Decomposition:
- Shared package/include (config.vh): state encoding constants S_IDLE=0, S_CMD=1, S_WAIT=2, S_ACK=3; owner encoding OWN_I=0, OWN_X=1.
- One natural sub-module: darkram_arb_pick, a combinational grant selector. Inputs: ireq, xreq, last_owner, HLT. Outputs: grant_valid, grant_x. It isolates the DARKRAM_ARB_RR_EN logic.

Test Plan:
- RAM model preloaded with word 4 = 0xDEADBEEF; IDREQ, IADDR=0x10, RD_LAT=1 -> RADDR=4 in cycle 1, IDACK only in cycle 3, IDATA=0xDEADBEEF, XATAO unchanged.
- X write XADDR=0x20, XBE=4'b0011, XATAI=0x1234ABCD -> RWE=1 only in cycle 1 with RADDR=8, RBE=0011, RDATI=0x1234ABCD; XDACK in cycle 2; read-back of word 8 returns low half updated.
- IDREQ and XDREQ/XRD high together, held continuously:
  - without RR: grant order X,X,X… and IDACK never asserts;
  - with DARKRAM_ARB_RR_EN: grant order X,I,X,I.
- HLT=1 with IDREQ pending -> no RADDR change, no ack for 10 cycles; HLT=0 -> IDACK 3 cycles later. HLT raised during CMD -> that access still acks.
- RES driven low mid-WAIT, asynchronously between edges -> all outputs 0 immediately, no ack. After release: state IDLE, and the held request is regranted.
- RD_LAT=3, X read -> XDACK in cycle 5. XDREQ with XRD=XWR=0 -> never granted, no ack.
